// File: rtl/latch_writer_pkg.sv
// Shared types and default timing for the latch bank writer.
// Phase lengths are in clock cycles.
package latch_writer_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_EN_CYC    = 1;
    localparam int DEF_HOLD_CYC  = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        CHECK
    } state_t;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/latch_writer_if.sv
// Request and latch-bank signals of the latch writer.
// The slave modport is the writer's view; the master modport is the driver/bank side.
interface latch_writer_if
    import latch_writer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] latch_d;
    logic             latch_en;
    logic [WIDTH-1:0] latch_q;
    logic             done;
    logic             err;

    modport master (
        output in_valid, in_data, latch_q,
        input  in_ready, latch_d, latch_en, done, err
    );

    modport slave (
        input  in_valid, in_data, latch_q,
        output in_ready, latch_d, latch_en, done, err
    );

endinterface

// File: rtl/lw_timer.sv
// Loadable down-counter with a zero flag, shared by the writer's timed phases.
// The count parks at zero instead of wrapping.
module lw_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_value,
    output logic          o_zero
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/latch_writer.sv
// Writes one word into an external latch bank with the required setup, strobe and hold timing.
// The bank is read back afterwards, and any mismatch is flagged on err.
module latch_writer
    import latch_writer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int EN_CYC    = DEF_EN_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic           clk,
    input  logic           rst_n,
    latch_writer_if.slave  bus
);

    localparam int CW = $clog2(maxOf3(SETUP_CYC, EN_CYC, HOLD_CYC) + 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_latchD;
    logic             r_latchEn;
    logic             r_done;
    logic             r_err;
    logic             w_accept;
    logic             w_load;
    logic [CW-1:0]    w_loadVal;
    logic             w_zero;

    assign w_accept = bus.in_valid && (r_state == IDLE);

    lw_timer #(.CW(CW)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_value (w_loadVal),
        .o_zero  (w_zero)
    );

    // Each timed phase reloads the shared timer with its own length on entry.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_loadVal   = '0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_nextState = SETUP;
                    w_load      = 1'b1;
                    w_loadVal   = SETUP_LD;
                end
            end
            SETUP: begin
                if (w_zero) begin
                    w_nextState = STROBE;
                    w_load      = 1'b1;
                    w_loadVal   = EN_LD;
                end
            end
            STROBE: begin
                if (w_zero) begin
                    w_nextState = HOLD;
                    w_load      = 1'b1;
                    w_loadVal   = HOLD_LD;
                end
            end
            HOLD: begin
                if (w_zero) begin
                    w_nextState = CHECK;
                end
            end
            CHECK: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Enable and done are decoded from the next state so both come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_latchD  <= '0;
            r_latchEn <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_latchEn <= (w_nextState == STROBE);
            r_done    <= (w_nextState == CHECK);
            if (w_accept) begin
                r_latchD <= bus.in_data;
            end
            if (r_state == CHECK) begin
                r_err <= (bus.latch_q != r_latchD);
            end
        end
    end

    assign bus.in_ready = (r_state == IDLE);
    assign bus.latch_d  = r_latchD;
    assign bus.latch_en = r_latchEn;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_latch_writer.sv
// Scoreboard bench for latch_writer: the stimulus queues expected results and a monitor checks them on each done.
// A second instance with stretched phase lengths is checked cycle by cycle.
module tb_latch_writer;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         acc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    int   doneSeen = 0;

    exp_t expQ[$];
    exp_t monE;
    int   enFirst = -1;
    int   enCount = 0;
    logic errPending = 1'b0;
    logic errExp = 1'b0;

    logic [7:0] latchModel = 8'h00;
    logic       stuck = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    latch_writer_if #(.WIDTH(8)) bus ();
    latch_writer_if #(.WIDTH(8)) bus2 ();

    latch_writer #(.WIDTH(8), .SETUP_CYC(2), .EN_CYC(1), .HOLD_CYC(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    latch_writer #(.WIDTH(8), .SETUP_CYC(3), .EN_CYC(2), .HOLD_CYC(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Transparent latch bank model; stuck forces the readback to zero.
    always @(bus.latch_en or bus.latch_d) begin
        if (bus.latch_en) latchModel = bus.latch_d;
    end
    assign bus.latch_q  = stuck ? 8'h00 : latchModel;
    assign bus2.latch_q = bus2.latch_d;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic expErr, input bit push,
                                 input bit hold, output int acc);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout: in_ready got 0, want 1");
            bus.in_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) expQ.push_back('{data: d, err: expErr, acc: acc});
        if (!hold) bus.in_valid = 1'b0;
    endtask

    // Monitor: every done pops one expectation and checks data, timing and the following err.
    always @(negedge clk) begin
        if (!rst_n) begin
            enFirst    = -1;
            enCount    = 0;
            errPending = 1'b0;
        end else begin
            if (errPending) begin
                checkOutput("err after CHECK", {31'd0, bus.err}, {31'd0, errExp});
                errPending = 1'b0;
            end
            if (bus.latch_en) begin
                if (enCount == 0) enFirst = cyc;
                enCount++;
            end
            if (bus.done) begin
                doneSeen++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected done: got done=1 at cycle %0d, want no done", cyc);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("latch_d at done", {24'd0, bus.latch_d}, {24'd0, monE.data});
                    checkOutput("done cycle", cyc, monE.acc + 4);
                    checkOutput("latch_en first cycle", enFirst, monE.acc + 2);
                    checkOutput("latch_en length", enCount, 1);
                    errExp     = monE.err;
                    errPending = 1'b1;
                end
                enFirst = -1;
                enCount = 0;
            end
        end
    end

    initial begin
        int a;
        int a2;
        int relCyc;
        int doneBefore;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus2.in_valid = 1'b0;
        bus2.in_data  = 8'h00;

        #2;
        checkOutput("reset in_ready", {31'd0, bus.in_ready}, 1);
        checkOutput("reset latch_en", {31'd0, bus.latch_en}, 0);
        checkOutput("reset latch_d", {24'd0, bus.latch_d}, 0);
        checkOutput("reset done", {31'd0, bus.done}, 0);
        checkOutput("reset err", {31'd0, bus.err}, 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        relCyc = cyc;

        // Basic write, accepted on the first edge after reset release.
        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0, a);
        checkOutput("first accept after reset", a, relCyc + 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("latch_d hold cycle %0d", k + 1), {24'd0, bus.latch_d}, 32'hA5);
        end
        repeat (2) @(negedge clk);

        // Readback mismatch, then a matching write clears err.
        stuck = 1'b1;
        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b0, a);
        repeat (6) @(negedge clk);
        checkOutput("err held in IDLE", {31'd0, bus.err}, 1);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, a);
        @(negedge clk);
        checkOutput("err held until next CHECK", {31'd0, bus.err}, 1);
        repeat (6) @(negedge clk);
        checkOutput("err cleared by matching write", {31'd0, bus.err}, 0);

        // Set err again, then reset in the middle of STROBE.
        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b0, a);
        repeat (6) @(negedge clk);
        stuck = 1'b0;
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, a);
        repeat (3) @(negedge clk);
        checkOutput("latch_en in STROBE before reset", {31'd0, bus.latch_en}, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset latch_en", {31'd0, bus.latch_en}, 0);
        checkOutput("mid reset latch_d", {24'd0, bus.latch_d}, 0);
        checkOutput("mid reset done", {31'd0, bus.done}, 0);
        checkOutput("mid reset err", {31'd0, bus.err}, 0);
        checkOutput("mid reset in_ready", {31'd0, bus.in_ready}, 1);
        @(negedge clk);
        rst_n      = 1'b1;
        doneBefore = doneSeen;
        repeat (8) @(negedge clk);
        checkOutput("no done after aborted write", doneSeen, doneBefore);

        // Request pulsed while busy is ignored.
        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0, a);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("latch_d ignores busy request", {24'd0, bus.latch_d}, 32'hA5);
        checkOutput("in_ready low while busy", {31'd0, bus.in_ready}, 0);
        repeat (8) @(negedge clk);

        // Back-to-back with in_valid held high.
        applyStimulus(8'h11, 1'b0, 1'b1, 1'b1, a);
        applyStimulus(8'h22, 1'b0, 1'b1, 1'b1, a2);
        bus.in_valid = 1'b0;
        checkOutput("back-to-back accept spacing", a2 - a, 6);
        repeat (8) @(negedge clk);

        // Stretched phases on the second instance.
        bus2.in_valid = 1'b1;
        bus2.in_data  = 8'h77;
        checkOutput("dut2 ready before write", {31'd0, bus2.in_ready}, 1);
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            checkOutput($sformatf("dut2 latch_en cycle %0d", k), {31'd0, bus2.latch_en},
                        {31'd0, (k == 4 || k == 5)});
            checkOutput($sformatf("dut2 done cycle %0d", k), {31'd0, bus2.done}, {31'd0, (k == 7)});
            checkOutput($sformatf("dut2 in_ready cycle %0d", k), {31'd0, bus2.in_ready}, {31'd0, (k == 8)});
            if (k < 8) begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("dut2 latch_d", {24'd0, bus2.latch_d}, 32'h77);
        checkOutput("dut2 err after matching readback", {31'd0, bus2.err}, 0);

        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/latch_writer.md
LATCH_WRITER -- requirements
Module: latch_writer

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 8, data width of the latch bank driven.
- SETUP_CYC, 2, cycles latch_d is stable before latch_en rises; minimum 1.
- EN_CYC, 1, cycles latch_en stays high; minimum 1.
- HOLD_CYC, 1, cycles latch_d is stable after latch_en falls; minimum 1.

REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  write request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  WIDTH  value to store.
- latch_d  output  WIDTH  data driven to the latch bank d inputs.
- latch_en  output  1  enable driven to the latch bank en inputs.
- latch_q  input  WIDTH  latch bank outputs, used for readback.
- done  output  1  one-cycle pulse marking transaction completion.
- err  output  1  readback mismatch flag for the last transaction.

Function
REQ-003 The FSM SHALL have the states IDLE, SETUP, STROBE, HOLD and CHECK.
REQ-004 in_ready SHALL equal (state == IDLE).
REQ-005 Accept SHALL occur on a rising edge where in_valid && in_ready; at that edge latch_d loads in_data and the state moves to SETUP.
REQ-006 latch_d SHALL change only on accept or reset and SHALL be held constant from SETUP through CHECK.
REQ-007 in_valid or in_data outside IDLE SHALL be ignored, with no effect on state, latch_d or err.
REQ-008 SETUP SHALL last exactly SETUP_CYC cycles, STROBE exactly EN_CYC cycles, HOLD exactly HOLD_CYC cycles and CHECK exactly 1 cycle; the next state after CHECK is IDLE.
REQ-009 latch_en SHALL be registered and high only in STROBE, with no glitch on state transitions.
REQ-010 With accept at edge ending cycle 0 and default parameters:
- SETUP occupies cycles 1-2.
- STROBE (latch_en=1) occupies cycle 3.
- HOLD occupies cycle 4.
- CHECK (done=1) occupies cycle 5.
- IDLE (in_ready=1) begins at cycle 6.
REQ-011 The busy length SHALL be SETUP_CYC+EN_CYC+HOLD_CYC+1 cycles.
REQ-012 In CHECK, the block SHALL compare latch_q to latch_d; err is registered at the edge leaving CHECK as (latch_q != latch_d) and holds until the next CHECK or reset.
REQ-013 done SHALL be high only during CHECK.
REQ-014 Back-to-back transfers: with in_valid held high, the next accept SHALL occur at the first IDLE cycle, giving a minimum 1-cycle IDLE gap between transactions.
REQ-015 Phase counters SHALL be sized $clog2(max(SETUP_CYC,EN_CYC,HOLD_CYC)+1) bits, load count-1 on phase entry and advance at 0, with no wrap beyond the phase.

Reset
REQ-016 While rst_n=0, outputs SHALL immediately take these values, independent of clk:
- state = IDLE
- latch_d = 0
- latch_en = 0
- done = 0
- err = 0
- in_ready = 1
REQ-017 Reset asserted mid-transaction (any state) SHALL abort it with no done pulse and no err update.
REQ-018 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-019 Package latch_writer_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-020 The sub-module lw_timer SHALL provide a loadable down-counter with a zero flag, instantiated once and shared by the SETUP, STROBE and HOLD phases.

Verification
REQ-021 Basic write: accept 0xA5 at cycle 0 with a latch model echoing d when en=1 -> latch_en=1 only in cycle 3, latch_d=0xA5 in cycles 1-5, done in cycle 5, err=0.
REQ-022 Mismatch: latch model stuck at 0x00, write 0x3C -> done in cycle 5, err=1 from cycle 6; a later matching write of 0x00 clears err.
REQ-023 Busy ignore: after accepting 0xA5, pulse in_valid with 0xFF in cycle 3 -> not accepted, latch_d stays 0xA5, exactly one done.
REQ-024 Back-to-back: in_valid held high with 0x11 then 0x22 -> accepts at cycles 0 and 6, done at cycles 5 and 11, latch_en high at cycles 3 and 9.
REQ-025 Reset mid-STROBE: rst_n low during cycle 3 -> latch_en, latch_d, done and err read 0 within the same cycle, in_ready=1; after release there is no done until a new accept.
REQ-026 Parameter sweep: SETUP_CYC=3, EN_CYC=2, HOLD_CYC=1 -> latch_en high in cycles 4-5, done in cycle 7, in_ready=1 at cycle 8.
